// File: rtl/regfile_mp_if.sv
// Decode/execute-side bus of the multi-port register file: read addresses and
// enables, the single write port, and per-port read data with valid flags.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD-1:0]      rs_en;
  logic [AW-1:0]         wd_reg;
  logic [XLEN-1:0]       wdv;
  logic                  wren;
  logic [NREAD*XLEN-1:0] rs_val;
  logic [NREAD-1:0]      rs_valid;

  modport master (
    output rs_addr, rs_en, wd_reg, wdv, wren,
    input  rs_val, rs_valid
  );

  modport slave (
    input  rs_addr, rs_en, wd_reg, wdv, wren,
    output rs_val, rs_valid
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised flop-based register file: one write port, NREAD independent
// read ports with 1- or 2-cycle latency, enable-controlled hold and optional write bypass.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int READ_LAT = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

  if (!(READ_LAT == 1 || READ_LAT == 2)) begin : g_bad_lat
    $error("regfile_mp: READ_LAT must be 1 or 2");
  end

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  // Out-of-range and hardwired-zero writes are dropped here, so entry 0 never leaves reset.
  assign wr_ok = bus.wren
              && ({1'b0, bus.wd_reg} < NREGS_W)
              && !(ZERO_REG != 0 && bus.wd_reg == '0);

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(i);

    // NOTE: the array sits in plain flops with an async clear, so it is reset
    // like any other state; a RAM macro could not honour this.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (wr_ok && bus.wd_reg == IDX) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // reader sees pre-edge contents regardless of process order.
        regs[i] <= bus.wdv;
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] s1_data;
    logic            s1_valid;

    assign addr = bus.rs_addr[p*AW +: AW];

    always_comb begin
      // NOTE: defaulting before the conditions keeps this purely combinational
      // (no inferred latch on the paths that do not assign).
      rd_val = '0;
      if (({1'b0, addr} < NREGS_W) && !(ZERO_REG != 0 && addr == '0)) begin
        if (BYPASS != 0 && bus.wren && bus.wd_reg == addr) begin
          rd_val = bus.wdv;
        end else begin
          rd_val = regs[addr];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
      end else if (bus.rs_en[p]) begin
        s1_data  <= rd_val;
        s1_valid <= 1'b1;
      end
    end

    if (READ_LAT == 2) begin : g_lat2
      logic [XLEN-1:0] s2_data;
      logic            s2_valid;

      // Stage 2 only advances on enabled edges, so a disabled port freezes its whole pipe.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else if (bus.rs_en[p]) begin
          s2_data  <= s1_data;
          s2_valid <= s1_valid;
        end
      end

      assign bus.rs_val[p*XLEN +: XLEN] = s2_data;
      assign bus.rs_valid[p]            = s2_valid;
    end else begin : g_lat1
      assign bus.rs_val[p*XLEN +: XLEN] = s1_data;
      assign bus.rs_valid[p]            = s1_valid;
    end
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Generalises data width, register count, read-port count and read latency (1 or 2 cycles).
- Adds an async reset that clears the array, per-port read enables with hold, read-valid flags, optional write-to-read bypass, and out-of-range address handling.
- Sits between decode (addresses) and execute (operand values) in the pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; need not be a power of 2.
- NREAD, 2, number of independent read ports.
- READ_LAT, 2, read latency in cycles; legal values 1 or 2, others are an elaboration error.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded into the captured read value.
- ZERO_REG, 1, 1 = register 0 is hardwired to 0: writes are ignored and reads return 0.
- Local AW = $clog2(NREGS), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rs_addr  input  NREAD*AW  read addresses; port p occupies bits [p*AW +: AW].
- rs_en  input  NREAD  per-port read enable.
- wd_reg  input  AW  write address.
- wdv  input  XLEN  write data.
- wren  input  1  write enable.
- rs_val  output  NREAD*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
- rs_valid  output  NREAD  port p's rs_val holds the result of an enabled read.

Behaviour:
- Reset:
  - rst asserted, asynchronously and immediately: all NREGS entries = 0, every pipeline stage data = 0, rs_val = 0, rs_valid = 0.
  - Deassertion is synchronised by the integrator. The first edge after deassertion behaves as a normal cycle.
  - Reset mid-read discards all in-flight reads; no stale rs_valid appears afterwards.
- Write, at posedge:
  - If wren=1, wd_reg < NREGS, and not (ZERO_REG=1 and wd_reg=0), then entry[wd_reg] <= wdv.
  - Otherwise the array is unchanged.
  - One write port only, so no write-write conflict exists.
- Read capture, port p, at posedge with rs_en[p]=1:
  - Stage-1 data <= value(rs_addr_p); stage-1 valid <= 1.
  - value(a) = 0 if a >= NREGS, or if ZERO_REG=1 and a=0.
  - Else, if BYPASS=1, wren=1 and wd_reg=a, value(a) = wdv (new data).
  - Else value(a) = entry[a] (old data, the pre-edge contents).
- Hold, rs_en[p]=0:
  - All of port p's stages keep their data and valid bits; rs_val and rs_valid are unchanged.
  - Held values are snapshots: later writes to the same address do not update them.
- Latency, measured from the capture edge:
  - READ_LAT=1: rs_val/rs_valid are driven directly from stage 1, visible after 1 edge.
  - READ_LAT=2: stage 1 advances to stage 2 on the next edge with rs_en[p]=1, visible after 2 enabled edges.
  - With rs_en held high, throughput is one read per cycle per port.
  - For a capture at edge N with READ_LAT=2, a write at edge N+1 is not reflected in that read's data.
- Ports are fully independent: identical addresses on several ports are legal and return identical data.
- Out-of-range write (wd_reg >= NREGS): silently dropped.
- Implementation constraints:
  - The array is flop-based, since async reset rules out RAM inference.
  - Read muxes and the bypass compare are combinational, ahead of stage 1.

Test Plan:
- Reset/zero: pulse rst mid-stream, then read all ports at addr 5 -> rs_val=0 and rs_valid=0 while rst is high; after the read latency, data=0 and rs_valid=1.
- Write/read latency (READ_LAT=2, BYPASS=0):
  - Write 0xDEADBEEF to r7; two cycles later read r7 on port 0 with rs_en=1 held -> 0xDEADBEEF on the 2nd edge after capture, rs_valid=1.
  - Re-run at READ_LAT=1 -> data appears on the 1st edge.
- Bypass:
  - Same cycle: wren=1, wd_reg=3, wdv=0x12345678, port 1 reads r3 -> BYPASS=1 yields 0x12345678; BYPASS=0 yields the old value 0.
  - Write at the next edge -> not reflected in that read.
- r0 and out-of-range (NREGS=24):
  - Write 0xFFFFFFFF to r0 then read r0 -> 0.
  - Write 0xAA to addr 30, then read addr 30 -> 0.
  - Read r23 -> its last written value, unaffected by the addr-30 write.
- Hold/multi-port (NREAD=3):
  - Ports read r1, r2, r1, then drop rs_en[1] for 3 cycles while r2 is rewritten -> port 1 holds the old r2 value with rs_valid unchanged; ports 0 and 2 track r1.
- Random: 10k cycles of random wren/wd_reg/rs_en/rs_addr against a reference model including bypass, hold and reset -> zero mismatches.
